fsmc_master: RTL
================

Name: fsmc_master

Overview:
- FSMC bus initiator for the multiplexed 18-bit AD bus; the host-side counterpart of our FPGA-resident FSMC slave interface.
- Converts single-word read/write requests into NADV/NWE/NOE bus cycles with programmable address-setup, address-hold, data-strobe and bus-turnaround phases.
- Used as the bus-functional driver in integration benches and as the bridge when one FPGA drives another FSMC-slave FPGA.

Parameters:
- ADDR_W, 18, address width; equals the AD bus width.
- DATA_W, 16, data width; carried on AD[15:0].
- ADDSET, 2, cycles NADV is held low with the address driven (legal range ≥1).
- ADDHLD, 1, cycles the address is held after NADV rises (≥0; 0 skips the phase).
- DATAST, 4, cycles NWE or NOE is held low (≥1).
- BUSTURN, 1, idle cycles after the strobe with AD[15:0] released (≥0; 0 skips the phase).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  master can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  18  bus address.
- req_wdata  input  16  write data.
- done  output  1  one-cycle pulse marking transaction completion.
- rdata  output  16  read data; valid while done is high after a read, then held.
- AD  inout  18  multiplexed address/data bus.
- NADV  output  1  address valid, active-low.
- NWE  output  1  write strobe, active-low.
- NOE  output  1  read strobe, active-low.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - NADV=NWE=NOE=1, AD fully high-Z, done=0, rdata=0, req_ready=1, state=IDLE.
  - A reset mid-transaction aborts it at that edge. No done pulse is produced.
- Strobes, AD drive enables and done are registered. Each changes on the edge that enters its state.
- FSM states: IDLE, ADDR, AHOLD, DATA, TURN. One down-counter is loaded on each phase entry.
- IDLE:
  - req_ready=1.
  - If req_valid & req_ready, latch we/addr/wdata and go to ADDR.
- ADDR, ADDSET cycles:
  - NADV=0, AD[17:0]=addr.
  - Next state is AHOLD, or DATA if ADDHLD=0.
- AHOLD, ADDHLD cycles:
  - NADV=1, AD[17:0]=addr.
- DATA, DATAST cycles:
  - NADV=1, AD[17:16]=addr[17:16] driven throughout.
  - Write: NWE=0, AD[15:0]=wdata.
  - Read: NOE=0, AD[15:0] high-Z. rdata captures AD[15:0] at the edge that ends the last DATA cycle.
- TURN, BUSTURN cycles:
  - All strobes 1, AD[15:0] high-Z, AD[17:16] still driven.
  - Go to IDLE. If BUSTURN=0, go from DATA directly to IDLE.
- Return to IDLE:
  - done=1 for exactly the first IDLE cycle. AD[17:16] released.
  - rdata is valid in that cycle for reads and unchanged for writes.
- Latency: accept edge to done-high cycle = ADDSET+ADDHLD+DATAST+BUSTURN+1 cycles (9 at defaults).
- Back-to-back: a request presented during the done cycle is accepted. ADDR starts on the next edge with no extra gap.
- req_ready=0 in every non-IDLE state. Request inputs are ignored outside IDLE; later changes do not affect an in-flight cycle.
- Invariants:
  - NADV, NWE and NOE are never low simultaneously in any pair.
  - AD[15:0] is never driven while NOE=0.
  - NWE/NOE low cycles equal DATAST exactly.
- Counter width is $clog2(max phase parameter + 1). Parameter values violating the legal ranges trigger an elaboration-time $error.

Test Plan:
- Write, defaults:
  - Stimulus: req_we=1, addr=0x2_0004, wdata=0xA5C3.
  - NADV low 2 cycles with AD=0x20004. One hold cycle. NWE low 4 cycles with AD=0x2A5C3. One turn cycle. done 9 cycles after accept.
- Read, defaults:
  - Stimulus: bench slave model drives 0x1234 on AD[15:0] while NOE=0, addr=0x00010.
  - NOE low exactly 4 cycles; AD[15:0] never driven by the master; rdata=0x1234 during done and held afterwards.
- Back-to-back:
  - Stimulus: write 0x0001@0x00000, then read @0x00001 presented during the done cycle.
  - Second NADV falls on the next edge; total 18 cycles for both transactions; no overlapping strobes.
- ADDHLD=0, BUSTURN=0:
  - Stimulus: read with ADDSET=1, DATAST=1.
  - NOE falls the cycle after NADV rises; done 3 cycles after accept.
- Reset mid-operation:
  - Stimulus: assert rst during the 2nd DATA cycle of a write.
  - Next cycle: NWE=1, AD high-Z, req_ready=1; no done pulse; the next request completes normally.
- Request stability:
  - Stimulus: change req_addr/req_wdata and toggle req_valid during an active transaction.
  - Bus values are unchanged; no extra transaction occurs.

Source files
------------

// File: rtl/fsmc_master.sv
// FSMC bus initiator: turns single-word read/write requests into NADV/NWE/NOE cycles on the muxed AD bus.
// Latency: accept edge to done-high cycle is ADDSET+ADDHLD+DATAST+BUSTURN+1 cycles.
// Backpressure: req_ready is high only in IDLE (including the done cycle); requests elsewhere are ignored.
module fsmc_master #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int ADDSET  = 2,
  parameter int ADDHLD  = 1,
  parameter int DATAST  = 4,
  parameter int BUSTURN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  inout  wire  [ADDR_W-1:0] AD,
  output logic              NADV,
  output logic              NWE,
  output logic              NOE
);

  // Reject phase settings that would break the bus timing.
  if (ADDSET < 1) begin : g_bad_addset
    $error("fsmc_master: ADDSET must be >= 1");
  end
  if (ADDHLD < 0) begin : g_bad_addhld
    $error("fsmc_master: ADDHLD must be >= 0");
  end
  if (DATAST < 1) begin : g_bad_datast
    $error("fsmc_master: DATAST must be >= 1");
  end
  if (BUSTURN < 0) begin : g_bad_busturn
    $error("fsmc_master: BUSTURN must be >= 0");
  end
  if (ADDR_W <= DATA_W) begin : g_bad_width
    $error("fsmc_master: ADDR_W must exceed DATA_W");
  end

  localparam int MAX_AB = (ADDSET > ADDHLD) ? ADDSET : ADDHLD;
  localparam int MAX_DT = (DATAST > BUSTURN) ? DATAST : BUSTURN;
  localparam int MAXP   = (MAX_AB > MAX_DT) ? MAX_AB : MAX_DT;
  localparam int CNT_W  = $clog2(MAXP + 1);

  // Counter load values: each phase lasts (load + 1) cycles.
  localparam logic [CNT_W-1:0] LD_ADDSET  = CNT_W'(ADDSET - 1);
  localparam logic [CNT_W-1:0] LD_ADDHLD  = (ADDHLD > 0) ? CNT_W'(ADDHLD - 1) : '0;
  localparam logic [CNT_W-1:0] LD_DATAST  = CNT_W'(DATAST - 1);
  localparam logic [CNT_W-1:0] LD_BUSTURN = (BUSTURN > 0) ? CNT_W'(BUSTURN - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    AHOLD,
    DATA,
    TURN
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept, capture;

  // Latched transaction, frozen for the whole bus cycle.
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   wdata_n;

  // Registered bus drivers.
  logic                nadv_q, nwe_q, noe_q, done_q;
  logic                ad_hi_oe, ad_lo_oe;
  logic [ADDR_W-1:0]   ad_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                nadv_d, nwe_d, noe_d, done_d;
  logic                ad_hi_oe_d, ad_lo_oe_d;
  logic [ADDR_W-1:0]   ad_d;

  assign req_ready = (state_q == IDLE);
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign NADV      = nadv_q;
  assign NWE       = nwe_q;
  assign NOE       = noe_q;

  assign AD[ADDR_W-1:DATA_W] = ad_hi_oe ? ad_q[ADDR_W-1:DATA_W] : {(ADDR_W-DATA_W){1'bz}};
  assign AD[DATA_W-1:0]      = ad_lo_oe ? ad_q[DATA_W-1:0]      : {DATA_W{1'bz}};

  // Next-state and phase counter: one down-counter reloaded on every phase entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ADDR;
          cnt_d   = LD_ADDSET;
        end
      end
      ADDR: begin
        if (cnt_q == '0) begin
          if (ADDHLD > 0) begin
            state_d = AHOLD;
            cnt_d   = LD_ADDHLD;
          end else begin
            state_d = DATA;
            cnt_d   = LD_DATAST;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      AHOLD: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = LD_DATAST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          capture = ~we_q;
          if (BUSTURN > 0) begin
            state_d = TURN;
            cnt_d   = LD_BUSTURN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      TURN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decoded from the state being entered so every strobe is registered.
  always_comb begin
    we_n       = accept ? req_we    : we_q;
    addr_n     = accept ? req_addr  : addr_q;
    wdata_n    = accept ? req_wdata : wdata_q;
    nadv_d     = ~(state_d == ADDR);
    nwe_d      = ~((state_d == DATA) && we_n);
    noe_d      = ~((state_d == DATA) && !we_n);
    ad_hi_oe_d = (state_d != IDLE);
    ad_lo_oe_d = (state_d == ADDR) || (state_d == AHOLD) || ((state_d == DATA) && we_n);
    done_d     = (state_q != IDLE) && (state_d == IDLE);
    if ((state_d == ADDR) || (state_d == AHOLD)) begin
      ad_d = addr_n;
    end else begin
      ad_d = {addr_n[ADDR_W-1:DATA_W], wdata_n};
    end
  end

  // State, counter and bus-driver registers; reset aborts any cycle without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      nadv_q   <= 1'b1;
      nwe_q    <= 1'b1;
      noe_q    <= 1'b1;
      done_q   <= 1'b0;
      ad_hi_oe <= 1'b0;
      ad_lo_oe <= 1'b0;
      ad_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nadv_q   <= nadv_d;
      nwe_q    <= nwe_d;
      noe_q    <= noe_d;
      done_q   <= done_d;
      ad_hi_oe <= ad_hi_oe_d;
      ad_lo_oe <= ad_lo_oe_d;
      ad_q     <= ad_d;
    end
  end

  // Request latch and read-data capture at the edge closing the last strobe cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (capture) begin
        rdata_q <= AD[DATA_W-1:0];
      end
    end
  end

endmodule
